// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a variable-latency req/ack port,
// holds the word for decode and computes the next PC from jump/branch redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        pcsrc,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        fetch_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        pcplus4_w;
    logic signed [31:0] br_off;
    logic [31:0]        br_target;
    logic [31:0]        jmp_target;
    logic [31:0]        next_pc;

    // Redirect targets are always derived from the held instruction.
    assign pcplus4_w  = pc_q + 32'd4;
    assign br_off     = signed'({{14{instr_q[15]}}, instr_q[15:0], 2'b00});
    assign br_target  = pcplus4_w + unsigned'(br_off);
    assign jmp_target = {pcplus4_w[31:28], instr_q[25:0], 2'b00};

    always_comb begin
        next_pc = pcplus4_w;
        if (jump) begin
            next_pc = jmp_target;
        end else if (pcsrc) begin
            next_pc = br_target;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // An ack in the last allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    pc_d    = {next_pc[31:2], 2'b00};
                    state_d = S_FETCH;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign instr_valid = (state_q == S_HOLD);
    assign pc          = pc_q;
    assign pcplus4     = pcplus4_w;
    assign fetch_err   = (state_q == S_ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of fetched words checked when instr_valid rises,
// plus PC redirect, back-pressure, timeout and asynchronous reset scenarios.
module tb_fetch_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [5:0]  op;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        jump = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        fetch_err;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .op(op), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .jump(jump), .pcsrc(pcsrc),
        .pc(pc), .pcplus4(pcplus4), .fetch_err(fetch_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called while the DUT is in the fetch state at exp_pc; acks after `waits` idle cycles.
    task automatic fetch(input logic [31:0] rdata, input logic [31:0] exp_pc, input int waits);
        exp_t e;
        chk("req_start", {31'b0, imem_req}, 32'd1);
        chk("addr", imem_addr, exp_pc);
        for (int i = 0; i < waits; i++) begin
            jump  = 1'b1;
            pcsrc = 1'b1;
            tick();
            chk("req_held", {31'b0, imem_req}, 32'd1);
            chk("pc_wait", pc, exp_pc);
            chk("err_wait", {31'b0, fetch_err}, 32'd0);
        end
        jump       = 1'b0;
        pcsrc      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        sb.push_back('{instr: rdata, pc: exp_pc});
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("valid", {31'b0, instr_valid}, 32'd1);
        chk("req_drop", {31'b0, imem_req}, 32'd0);
        e = sb.pop_front();
        chk("instr", instr, e.instr);
        chk("op", {26'b0, op}, {26'b0, e.instr[31:26]});
        chk("pc", pc, e.pc);
        chk("pcplus4", pcplus4, e.pc + 32'd4);
    endtask

    task automatic consume(input logic j, input logic b, input logic [31:0] exp_next);
        instr_ready = 1'b1;
        jump        = j;
        pcsrc       = b;
        tick();
        instr_ready = 1'b0;
        jump        = 1'b0;
        pcsrc       = 1'b0;
        chk("valid_gap", {31'b0, instr_valid}, 32'd0);
        chk("next_pc", pc, exp_next);
        chk("req_next", {31'b0, imem_req}, 32'd1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        reset = 1'b0;
        tick();

        // zero-wait fetch of the first instruction
        fetch(32'h2008_0005, 32'h0, 0);
        chk("t1_op", {26'b0, op}, {26'b0, 6'b001000});

        // back-pressure: everything held while decode stalls
        for (int i = 0; i < 4; i++) begin
            jump = 1'b1;
            tick();
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_instr", instr, 32'h2008_0005);
            chk("stall_pc", pc, 32'h0);
        end
        jump = 1'b0;
        consume(1'b0, 1'b0, 32'h4);

        // three wait states, then jump to 0x40
        fetch(32'h0800_0010, 32'h4, 3);
        consume(1'b1, 1'b0, 32'h40);

        // backward branch to itself, then forward branch by 3 words
        fetch(32'h1000_FFFF, 32'h40, 0);
        consume(1'b0, 1'b1, 32'h40);
        fetch(32'h1000_0003, 32'h40, 0);
        consume(1'b0, 1'b1, 32'h50);

        // climb to 0x1000_0000 via jump then a branch across the 256MB boundary
        fetch(32'h0BFF_FFFC, 32'h50, 1);
        consume(1'b1, 1'b0, 32'h0FFF_FFF0);
        fetch(32'h1000_0003, 32'h0FFF_FFF0, 0);
        consume(1'b0, 1'b1, 32'h1000_0000);

        // jump has priority over a taken branch
        fetch(32'h0800_0010, 32'h1000_0000, 0);
        consume(1'b1, 1'b1, 32'h1000_0040);

        // ack in the final allowed cycle is accepted
        fetch(32'h2008_0005, 32'h1000_0040, TIMEOUT - 1);
        chk("late_ack_err", {31'b0, fetch_err}, 32'd0);
        consume(1'b0, 1'b0, 32'h1000_0044);

        // no ack at all -> timeout fault
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            chk("to_req", {31'b0, imem_req}, 32'd1);
            chk("to_err", {31'b0, fetch_err}, 32'd0);
        end
        tick();
        chk("err_set", {31'b0, fetch_err}, 32'd1);
        chk("err_req", {31'b0, imem_req}, 32'd0);
        chk("err_valid", {31'b0, instr_valid}, 32'd0);
        imem_ack = 1'b1;
        tick();
        tick();
        imem_ack = 1'b0;
        chk("err_sticky", {31'b0, fetch_err}, 32'd1);
        chk("err_sticky_valid", {31'b0, instr_valid}, 32'd0);

        reset = 1'b1;
        #1;
        chk("err_rst_clr", {31'b0, fetch_err}, 32'd0);
        chk("err_rst_pc", pc, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // wrap-around: branch back from 0 to 0xFFFF_FFFC, then +4 wraps to 0
        fetch(32'h1000_FFFE, 32'h0, 0);
        consume(1'b0, 1'b1, 32'hFFFF_FFFC);
        fetch(32'h2008_0005, 32'hFFFF_FFFC, 0);
        chk("wrap_pcplus4", pcplus4, 32'h0);
        consume(1'b0, 1'b0, 32'h0);
        fetch(32'h2008_0005, 32'h0, 0);
        consume(1'b0, 1'b0, 32'h4);

        // asynchronous reset mid-fetch with a stray ack
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rf_req", {31'b0, imem_req}, 32'd0);
        chk("rf_pc", pc, 32'h0);
        chk("rf_addr", imem_addr, 32'h0);
        chk("rf_instr", instr, 32'h0);
        tick();
        chk("rf_stray_instr", instr, 32'h0);
        chk("rf_stray_valid", {31'b0, instr_valid}, 32'd0);
        reset = 1'b0;
        tick();
        imem_ack = 1'b0;
        chk("rf_rel_req", {31'b0, imem_req}, 32'd1);
        chk("rf_rel_valid", {31'b0, instr_valid}, 32'd0);
        chk("rf_rel_instr", instr, 32'h0);

        // asynchronous reset mid-hold with a stray ack
        fetch(32'h1234_5678, 32'h0, 0);
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rh_valid", {31'b0, instr_valid}, 32'd0);
        chk("rh_instr", instr, 32'h0);
        chk("rh_op", {26'b0, op}, 32'd0);
        chk("rh_pc", pc, 32'h0);
        tick();
        tick();
        chk("rh_stray_instr", instr, 32'h0);
        reset = 1'b0;
        tick();
        imem_ack = 1'b0;
        chk("rh_rel_req", {31'b0, imem_req}, 32'd1);
        chk("rh_rel_instr", instr, 32'h0);
        chk("rh_rel_valid", {31'b0, instr_valid}, 32'd0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
